// File: rtl/tracker_pkg.sv
// Shared NoC flit formats and message types for the tracker log protocol.
// Both request and response flits are packed structs sized here.
package tracker_pkg;

  localparam int NOC_XY_W = 4;
  localparam int TRACKER_ADDR_FW = 16;

  typedef enum logic [1:0] {
    TRACKER_META_REQ  = 2'd0,
    TRACKER_RD_REQ    = 2'd1,
    TRACKER_META_RESP = 2'd2,
    TRACKER_RD_RESP   = 2'd3
  } tracker_msg_t;

  typedef struct packed {
    logic [15:0] event_id;
    logic [31:0] timestamp;
  } tracker_stats_struct;

  localparam int TRACKER_STATS_W = $bits(tracker_stats_struct);

  typedef struct packed {
    tracker_msg_t                msg_type;
    logic [NOC_XY_W-1:0]         dst_x;
    logic [NOC_XY_W-1:0]         dst_y;
    logic [NOC_XY_W-1:0]         src_x;
    logic [NOC_XY_W-1:0]         src_y;
    logic [TRACKER_ADDR_FW-1:0]  addr;
  } tracker_req_flit;

  localparam int TRACKER_REQ_FLIT_W = $bits(tracker_req_flit);

  typedef struct packed {
    tracker_msg_t                msg_type;
    logic [NOC_XY_W-1:0]         dst_x;
    logic [NOC_XY_W-1:0]         dst_y;
    logic                        has_wrapped;
    logic [TRACKER_ADDR_FW-1:0]  curr_wr_addr;
    tracker_stats_struct         stats;
  } tracker_resp_flit;

  localparam int TRACKER_RESP_FLIT_W = $bits(tracker_resp_flit);

  typedef enum logic [2:0] {
    S_IDLE,
    S_META_REQ,
    S_META_RESP,
    S_RD_REQ,
    S_RD_RESP,
    S_ENTRY_OUT,
    S_DONE
  } client_state_t;

endpackage

// File: rtl/tracker_log_client_ctrl.sv
// Drain sequencer: one outstanding request, handshakes, sticky error.
// Datapath updates are issued as single-cycle strobes.
module tracker_log_client_ctrl
  import tracker_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_val,
  output logic       start_rdy,
  output logic       req_val,
  input  logic       req_rdy,
  output logic       req_meta,
  input  logic       resp_val,
  output logic       resp_rdy,
  input  logic [1:0] resp_type,
  input  logic       meta_zero,
  input  logic       rem_one,
  output logic       entry_val,
  input  logic       entry_rdy,
  output logic       entry_last,
  output logic       done,
  output logic       err,
  output logic       meta_load,
  output logic       rd_load,
  output logic       entry_adv
);

  client_state_t state_q, state_d;
  logic          err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    start_rdy  = 1'b0;
    req_val    = 1'b0;
    req_meta   = 1'b0;
    resp_rdy   = 1'b0;
    entry_val  = 1'b0;
    entry_last = 1'b0;
    done       = 1'b0;
    meta_load  = 1'b0;
    rd_load    = 1'b0;
    entry_adv  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        start_rdy = 1'b1;
        if (start_val) begin
          err_d   = 1'b0;
          state_d = S_META_REQ;
        end
      end
      S_META_REQ: begin
        req_val  = 1'b1;
        req_meta = 1'b1;
        if (req_rdy) state_d = S_META_RESP;
      end
      S_META_RESP: begin
        resp_rdy = 1'b1;
        if (resp_val) begin
          if (resp_type == TRACKER_META_RESP) begin
            meta_load = 1'b1;
            state_d   = meta_zero ? S_DONE : S_RD_REQ;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RD_REQ: begin
        req_val = 1'b1;
        if (req_rdy) state_d = S_RD_RESP;
      end
      S_RD_RESP: begin
        resp_rdy = 1'b1;
        if (resp_val) begin
          if (resp_type == TRACKER_RD_RESP) begin
            rd_load = 1'b1;
            state_d = S_ENTRY_OUT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ENTRY_OUT: begin
        entry_val  = 1'b1;
        entry_last = rem_one;
        if (entry_rdy) begin
          entry_adv = 1'b1;
          state_d   = rem_one ? S_DONE : S_RD_REQ;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign err = err_q;

endmodule

// File: rtl/tracker_log_client_datap.sv
// Read pointer, remaining count, entry register and flit pack/unpack.
// remaining is one bit wider so a fully wrapped log fits.
module tracker_log_client_datap
  import tracker_pkg::*;
#(
  parameter int SRC_X      = 0,
  parameter int SRC_Y      = 0,
  parameter int DST_X      = 0,
  parameter int DST_Y      = 0,
  parameter int ADDR_W     = 4,
  parameter int REQ_NOC_W  = TRACKER_REQ_FLIT_W,
  parameter int RESP_NOC_W = TRACKER_RESP_FLIT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       meta_load,
  input  logic                       rd_load,
  input  logic                       entry_adv,
  input  logic                       req_meta,
  input  logic [RESP_NOC_W-1:0]      resp_data,
  output logic [REQ_NOC_W-1:0]       req_data,
  output logic [1:0]                 resp_type,
  output logic                       meta_zero,
  output logic                       rem_one,
  output logic [TRACKER_STATS_W-1:0] entry_data
);

  logic [ADDR_W-1:0]          rd_addr_q, rd_addr_d;
  logic [ADDR_W:0]            remaining_q, remaining_d;
  logic [TRACKER_STATS_W-1:0] entry_data_q, entry_data_d;
  tracker_resp_flit           resp;
  tracker_req_flit            req;
  logic [ADDR_W-1:0]          wr_addr;
  logic                       unused_resp;

  assign resp    = tracker_resp_flit'(resp_data[TRACKER_RESP_FLIT_W-1:0]);
  assign wr_addr = resp.curr_wr_addr[ADDR_W-1:0];
  assign unused_resp = ^{resp.dst_x, resp.dst_y, resp.curr_wr_addr};

  assign resp_type = resp.msg_type;
  assign meta_zero = !resp.has_wrapped && (wr_addr == '0);
  assign rem_one   = (remaining_q == (ADDR_W+1)'(1));

  always_comb begin
    rd_addr_d    = rd_addr_q;
    remaining_d  = remaining_q;
    entry_data_d = entry_data_q;
    if (meta_load) begin
      if (resp.has_wrapped) begin
        rd_addr_d   = wr_addr;
        remaining_d = {1'b1, {ADDR_W{1'b0}}};
      end else begin
        rd_addr_d   = '0;
        remaining_d = {1'b0, wr_addr};
      end
    end
    if (rd_load) entry_data_d = resp.stats;
    if (entry_adv) begin
      rd_addr_d   = rd_addr_q + ADDR_W'(1);
      remaining_d = remaining_q - (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q    <= '0;
      remaining_q  <= '0;
      entry_data_q <= '0;
    end else begin
      rd_addr_q    <= rd_addr_d;
      remaining_q  <= remaining_d;
      entry_data_q <= entry_data_d;
    end
  end

  always_comb begin
    req          = '0;
    req.msg_type = req_meta ? TRACKER_META_REQ : TRACKER_RD_REQ;
    req.dst_x    = NOC_XY_W'(DST_X);
    req.dst_y    = NOC_XY_W'(DST_Y);
    req.src_x    = NOC_XY_W'(SRC_X);
    req.src_y    = NOC_XY_W'(SRC_Y);
    req.addr     = req_meta ? '0 : TRACKER_ADDR_FW'(rd_addr_q);
  end

  assign req_data   = REQ_NOC_W'(req);
  assign entry_data = entry_data_q;

endmodule

// File: rtl/tracker_log_client.sv
// Drains a remote tracker log over the NoC and streams its entries.
// Control and datapath are split into two submodules.
module tracker_log_client
  import tracker_pkg::*;
#(
  parameter int SRC_X      = 0,
  parameter int SRC_Y      = 0,
  parameter int DST_X      = 0,
  parameter int DST_Y      = 0,
  parameter int ADDR_W     = 4,
  parameter int REQ_NOC_W  = TRACKER_REQ_FLIT_W,
  parameter int RESP_NOC_W = TRACKER_RESP_FLIT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_val,
  output logic                       start_rdy,
  output logic                       client_req_noc_val,
  output logic [REQ_NOC_W-1:0]       client_req_noc_data,
  input  logic                       noc_client_req_rdy,
  input  logic                       noc_client_resp_val,
  input  logic [RESP_NOC_W-1:0]      noc_client_resp_data,
  output logic                       client_noc_resp_rdy,
  output logic                       entry_val,
  output logic [TRACKER_STATS_W-1:0] entry_data,
  output logic                       entry_last,
  input  logic                       entry_rdy,
  output logic                       done,
  output logic                       err
);

  logic       req_meta;
  logic [1:0] resp_type;
  logic       meta_zero;
  logic       rem_one;
  logic       meta_load;
  logic       rd_load;
  logic       entry_adv;

  tracker_log_client_ctrl u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_val  (start_val),
    .start_rdy  (start_rdy),
    .req_val    (client_req_noc_val),
    .req_rdy    (noc_client_req_rdy),
    .req_meta   (req_meta),
    .resp_val   (noc_client_resp_val),
    .resp_rdy   (client_noc_resp_rdy),
    .resp_type  (resp_type),
    .meta_zero  (meta_zero),
    .rem_one    (rem_one),
    .entry_val  (entry_val),
    .entry_rdy  (entry_rdy),
    .entry_last (entry_last),
    .done       (done),
    .err        (err),
    .meta_load  (meta_load),
    .rd_load    (rd_load),
    .entry_adv  (entry_adv)
  );

  tracker_log_client_datap #(
    .SRC_X      (SRC_X),
    .SRC_Y      (SRC_Y),
    .DST_X      (DST_X),
    .DST_Y      (DST_Y),
    .ADDR_W     (ADDR_W),
    .REQ_NOC_W  (REQ_NOC_W),
    .RESP_NOC_W (RESP_NOC_W)
  ) u_datap (
    .clk        (clk),
    .rst_n      (rst_n),
    .meta_load  (meta_load),
    .rd_load    (rd_load),
    .entry_adv  (entry_adv),
    .req_meta   (req_meta),
    .resp_data  (noc_client_resp_data),
    .req_data   (client_req_noc_data),
    .resp_type  (resp_type),
    .meta_zero  (meta_zero),
    .rem_one    (rem_one),
    .entry_data (entry_data)
  );

endmodule

// File: doc/tracker_log_client.md
TRACKER_LOG_CLIENT -- requirements
Module: tracker_log_client

Interface
REQ-001 SHALL have parameters: SRC_X (-1, own NoC X coordinate); SRC_Y (-1, own NoC Y); DST_X (-1, tracker X); DST_Y (-1, tracker Y); ADDR_W (-1, tracker log address width, equal to the tracker's TRACKER_DEPTH_LOG2); REQ_NOC_W (-1, request flit width); RESP_NOC_W (-1, response flit width).
REQ-002 SHALL have ports, one clock domain:
 clk  in  1  clock
 rst_n  in  1  asynchronous active-low reset
 start_val  in  1  request to drain the remote tracker log
 start_rdy  out  1  client idle, start accepted
 client_req_noc_val  out  1  request flit valid
 client_req_noc_data  out  REQ_NOC_W  request flit (tracker_req_flit)
 noc_client_req_rdy  in  1  NoC accepts request
 noc_client_resp_val  in  1  response flit valid
 noc_client_resp_data  in  RESP_NOC_W  response flit (tracker_resp_flit)
 client_noc_resp_rdy  out  1  client accepts response
 entry_val  out  1  log entry valid
 entry_data  out  TRACKER_STATS_W  tracker_stats_struct entry
 entry_last  out  1  final entry of drain
 entry_rdy  in  1  consumer accepts entry
 done  out  1  one-cycle pulse at drain completion
 err  out  1  sticky: unexpected response type seen; cleared on start

Function
REQ-003 SHALL use valid/ready handshakes; transfer occurs when val and rdy are both high on a rising clk edge; val SHALL NOT drop and data SHALL NOT change until transfer.
REQ-004 SHALL have states IDLE, META_REQ, META_RESP, RD_REQ, RD_RESP, ENTRY_OUT, DONE.
REQ-005 IDLE: start_rdy=1; on start handshake clear err and go to META_REQ.
REQ-006 META_REQ: drive request with msg_type=TRACKER_META_REQ, dst=(DST_X,DST_Y), src=(SRC_X,SRC_Y), addr=0; on handshake go to META_RESP.
REQ-007 META_RESP: client_noc_resp_rdy=1; on a META_RESP-type flit latch curr_wr_addr and has_wrapped; if has_wrapped, rd_addr=curr_wr_addr and remaining=2^ADDR_W; else rd_addr=0 and remaining=curr_wr_addr.
REQ-008 After REQ-007, remaining==0 SHALL go to DONE without issuing reads or entries; otherwise RD_REQ.
REQ-009 RD_REQ: drive msg_type=TRACKER_RD_REQ, addr=rd_addr; on handshake go to RD_RESP; at most one request outstanding.
REQ-010 RD_RESP: client_noc_resp_rdy=1; on RD_RESP-type flit register its tracker_stats_struct payload to entry_data, go to ENTRY_OUT.
REQ-011 ENTRY_OUT: entry_val=1; entry_last=1 iff remaining==1; on handshake rd_addr increments modulo 2^ADDR_W, remaining decrements; remaining reaching 0 goes to DONE, else RD_REQ.
REQ-012 remaining SHALL be ADDR_W+1 bits wide, so a full wrapped log (2^ADDR_W entries) is representable.
REQ-013 In META_RESP or RD_RESP a flit of the wrong msg_type SHALL be consumed and dropped, set err, and leave state unchanged.
REQ-014 client_noc_resp_rdy SHALL be 0 in all states other than META_RESP/RD_RESP.
REQ-015 DONE: done=1 for exactly one cycle, then IDLE.
REQ-016 start_val in any non-IDLE state SHALL be ignored (start_rdy=0).
REQ-017 Latency with ready-high neighbours and a one-cycle NoC turnaround: one request flit per entry; entry_val no earlier than the cycle after response acceptance.

Reset
REQ-018 rst_n low SHALL asynchronously force IDLE, all val outputs 0, done=0, err=0, entry_last=0, start_rdy=1 after deassertion, and clear rd_addr/remaining/latched metadata; reset mid-drain SHALL abandon it without done.
REQ-019 Responses to requests outstanding across reset are the system's responsibility; after reset they are dropped in IDLE (rdy=0 holds them).

Structure
REQ-020 tracker_pkg SHALL hold tracker_req_flit and tracker_resp_flit structs, msg_type enum (TRACKER_META_REQ, TRACKER_RD_REQ, TRACKER_META_RESP, TRACKER_RD_RESP), and their widths; TRACKER_STATS_W/tracker_stats_struct are reused unchanged.
REQ-021 SHALL be split into tracker_log_client_ctrl (FSM, handshakes) and tracker_log_client_datap (address/count, flit pack/unpack registers) instantiated in tracker_log_client.

Verification
REQ-022 ADDR_W=4, meta {curr_wr_addr=3, wrapped=0} -> reads addr 0,1,2; 3 entries, entry_last on 3rd, one done pulse.
REQ-023 meta {curr_wr_addr=5, wrapped=1} -> 16 reads addr 5..15,0..4; entry_last on 16th.
REQ-024 meta {curr_wr_addr=0, wrapped=0} -> no read requests, no entries, done pulses.
REQ-025 Random stalls on noc_client_req_rdy/entry_rdy -> data stable while stalled, entry order and content match tracker memory.
REQ-026 RD_RESP-type flit injected in META_RESP -> err=1, flit dropped, drain completes after correct META_RESP; err cleared on next start.
REQ-027 rst_n asserted mid-drain after 2 entries -> all outputs at reset values immediately, no done; subsequent start drains from the metadata read anew.
